// File: rtl/przerwanie_pkg.sv
// przerwanie_pkg: shared FSM states, default vector layout and vector arithmetic
package przerwanie_pkg;
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;
    localparam logic [7:0] DEF_VEC_BASE = 8'hF0;
    localparam int DEF_VEC_STRIDE = 2;
    function automatic int unsigned vec_calc(input int unsigned base, input int unsigned id,
                                             input int unsigned stride);
        return base + id * stride;
    endfunction
endpackage

// File: rtl/przerwanie_src.sv
// przerwanie_src: one interrupt source - synchroniser, edge detect and pending flag
module przerwanie_src
    import przerwanie_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src_i,
    input  logic mode_i,
    input  logic clr_i,
    output logic pend_o
);
    logic s;
    logic s_q, prev_q, pend_q, pend_d;
    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        always_ff @(posedge clk)
            if (!rst) sync_q <= '0;
            else      sync_q <= SYNC_STAGES'({sync_q, src_i});
        assign s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
        assign s = src_i;
    end
    // edge mode: a new rising edge beats a simultaneous ack-clear
    always_comb pend_d = mode_i ? ((s_q & ~prev_q) | (pend_q & ~clr_i)) : s_q;
    always_ff @(posedge clk)
        if (!rst) begin
            s_q    <= 1'b0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            s_q    <= s;
            prev_q <= s_q;
            pend_q <= pend_d;
        end
    assign pend_o = pend_q;
endmodule

// File: rtl/przerwanie_ctrl.sv
// przerwanie_ctrl: N-source fixed-priority interrupt controller with auto-CLI on ack
module przerwanie_ctrl
    import przerwanie_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int VEC_W = 8,
    parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'(DEF_VEC_BASE),
    parameter int VEC_STRIDE = DEF_VEC_STRIDE,
    parameter int SYNC_STAGES = 2,
    localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             int_enable,
    input  logic             int_disable,
    input  logic [N_SRC-1:0] src,
    input  logic [N_SRC-1:0] src_mode,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             int_ack,
    input  logic             int_reti,
    output logic             przerwanie,
    output logic [VEC_W-1:0] int_vector,
    output logic [ID_W-1:0]  int_id,
    output logic [N_SRC-1:0] pending,
    output logic             gie
);
    state_e             state_q, state_d;
    logic               irq_q, irq_d, gie_q, gie_d;
    logic [ID_W-1:0]    id_q, id_d, sel;
    logic [VEC_W-1:0]   vec_q, vec_d, sel_vec;
    logic [N_SRC-1:0]   mask_q, pend, req, clr;
    logic               ack_v, reti_v;
    assign ack_v  = int_ack && (state_q == REQ);
    assign reti_v = int_reti && (state_q == SERVICE);
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign clr[i] = ack_v && (id_q == ID_W'(i));
        przerwanie_src #(.SYNC_STAGES(SYNC_STAGES)) u_src (
            .clk(clk), .rst(rst), .src_i(src[i]), .mode_i(src_mode[i]),
            .clr_i(clr[i]), .pend_o(pend[i])
        );
    end
    assign req = pend & mask_q;
    always_comb begin
        sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--) if (req[i]) sel = ID_W'(i);
    end
    assign sel_vec = VEC_W'(vec_calc(32'(VEC_BASE), 32'(sel), 32'(VEC_STRIDE)));
    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        id_d    = id_q;
        vec_d   = vec_q;
        gie_d   = (ack_v || int_disable) ? 1'b0 : (reti_v || int_enable) ? 1'b1 : gie_q;
        case (state_q)
            IDLE: if (gie_q && |req) begin
                state_d = REQ;
                irq_d   = 1'b1;
                id_d    = sel;
                vec_d   = sel_vec;
            end
            REQ: if (int_ack) begin
                state_d = SERVICE;
                irq_d   = 1'b0;
            end else if (!gie_q || !mask_q[id_q] || !pend[id_q]) begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
            SERVICE: if (int_reti) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (!rst) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            gie_q   <= 1'b0;
            id_q    <= '0;
            vec_q   <= '0;
            mask_q  <= '1;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            gie_q   <= gie_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
            if (mask_we) mask_q <= mask_wdata;
        end
    assign przerwanie = irq_q;
    assign int_vector = vec_q;
    assign int_id     = id_q;
    assign pending    = pend;
    assign gie        = gie_q;
endmodule
